// File: rtl/async_rst_evt_pkg.sv
// async_rst_evt_pkg: shared FSM type, defaults and hold-counter width helper
`timescale 1ns/1ps
package async_rst_evt_pkg;
  typedef enum logic {IDLE, HOLD} state_e;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RST_CYCLES = 8;
  localparam int DEF_CNT_W = 8;
  function automatic int hold_w(input int cycles);
    return cycles > 1 ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/async_evt_chan.sv
// async_evt_chan: one channel - async capture, synchroniser, hold FSM, sticky status, saturating counter
`timescale 1ns/1ps
module async_evt_chan
  import async_rst_evt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tm,
  input  logic             evt,
  input  logic             mask,
  input  logic             sts_clr,
  output logic             rstn_out,
  output logic             sts,
  output logic [CNT_W-1:0] cnt
);
  localparam int HW = hold_w(RST_CYCLES);
  localparam logic [HW-1:0] RELOAD = HW'(RST_CYCLES - 1);
  logic evt_g, cap_q, cap_rst_n, cap_s, hit, done;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic ack_q, ack_d, active_q, active_d, sts_q, sts_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  assign evt_g = evt & ~mask;
  assign cap_rst_n = tm ? rst_n : rst_n & ~ack_q;
  always_ff @(posedge evt_g or negedge cap_rst_n)
    if (!cap_rst_n) cap_q <= 1'b0;
    else cap_q <= 1'b1;
  assign cap_s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], cap_q};
    hit = cap_s & ~ack_q;
    done = (state_q == HOLD) & (hold_q == '0) & ~cap_s & ~ack_q;
    state_d = hit ? HOLD : done ? IDLE : state_q;
    hold_d = hit ? RELOAD : hold_q != '0 ? hold_q - 1'b1 : hold_q;
    ack_d = hit | (ack_q & cap_s);
    active_d = hit | (active_q & ~done);
    sts_d = hit | (sts_q & ~sts_clr);
    evt_cnt_d = hit & ~&evt_cnt_q ? evt_cnt_q + 1'b1 : evt_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= IDLE;
      hold_q <= '0;
      ack_q <= 1'b0;
      active_q <= 1'b0;
      sts_q <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      hold_q <= hold_d;
      ack_q <= ack_d;
      active_q <= active_d;
      sts_q <= sts_d;
      evt_cnt_q <= evt_cnt_d;
    end
  assign rstn_out = ~(cap_q | active_q);
  assign sts = sts_q;
  assign cnt = evt_cnt_q;
endmodule

// File: rtl/async_reset_event_mc.sv
// async_reset_event_mc: multi-channel async event catcher driving per-channel and combined resets
`timescale 1ns/1ps
module async_reset_event_mc
  import async_rst_evt_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    sysclk,
  input  logic                    sys_rstn,
  input  logic                    ATPG_TM,
  input  logic                    ATPG_RSTN,
  input  logic [NUM_CH-1:0]       Async_reset_event,
  input  logic [NUM_CH-1:0]       evt_mask,
  input  logic [NUM_CH-1:0]       sts_clr,
  output logic [NUM_CH-1:0]       evt_rstn_out,
  output logic                    any_rstn_out,
  output logic [NUM_CH-1:0]       evt_sts,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt
);
  logic rstn_int;
  logic [NUM_CH-1:0] chan_rstn;
  if (SYNC_STAGES < 2 || RST_CYCLES < SYNC_STAGES + 2) begin : g_bad_cfg
    $error("async_reset_event_mc: need SYNC_STAGES >= 2 and RST_CYCLES >= SYNC_STAGES+2");
  end
  assign rstn_int = ATPG_TM ? ATPG_RSTN : sys_rstn;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    async_evt_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .RST_CYCLES(RST_CYCLES),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk(sysclk),
      .rst_n(rstn_int),
      .tm(ATPG_TM),
      .evt(Async_reset_event[g]),
      .mask(evt_mask[g]),
      .sts_clr(sts_clr[g]),
      .rstn_out(chan_rstn[g]),
      .sts(evt_sts[g]),
      .cnt(evt_cnt[g*CNT_W +: CNT_W])
    );
  end
  assign evt_rstn_out = ATPG_TM ? {NUM_CH{ATPG_RSTN}} : chan_rstn;
  assign any_rstn_out = &evt_rstn_out;
endmodule

// File: tb/tb_async_reset_event_mc.sv
// tb_async_reset_event_mc: scoreboard bench checking reset windows, counters, status, mask and ATPG control
`timescale 1ns/1ps
module tb_async_reset_event_mc;
  typedef struct {
    int ch;
    int cnt;
    int dmin;
    int dmax;
  } win_t;
  logic clk, sys_rstn, atpg_tm, atpg_rstn, any_rstn_out;
  logic [3:0] evt, evt_mask, sts_clr, evt_rstn_out, evt_sts, prev_out;
  logic [31:0] evt_cnt;
  int vectors, miscompares;
  bit mon_en;
  time fall_t [4];
  win_t sb [$];
  async_reset_event_mc dut (
    .sysclk(clk),
    .sys_rstn(sys_rstn),
    .ATPG_TM(atpg_tm),
    .ATPG_RSTN(atpg_rstn),
    .Async_reset_event(evt),
    .evt_mask(evt_mask),
    .sts_clr(sts_clr),
    .evt_rstn_out(evt_rstn_out),
    .any_rstn_out(any_rstn_out),
    .evt_sts(evt_sts),
    .evt_cnt(evt_cnt)
  );
  initial clk = 1'b0;
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_window(input int ch, input int d);
    win_t w;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      w = sb.pop_front();
      chk("win_ch", ch, w.ch);
      chk("win_len_in_range", 32'(d >= w.dmin && d <= w.dmax), 1);
      if (d < w.dmin || d > w.dmax) $display("  window length %0d ns, allowed %0d..%0d", d, w.dmin, w.dmax);
      chk("win_cnt", 32'(evt_cnt[ch*8 +: 8]), w.cnt);
    end
  endtask
  initial prev_out = 4'hF;
  always @(evt_rstn_out) begin
    for (int i = 0; i < 4; i++) begin
      if (prev_out[i] && !evt_rstn_out[i]) fall_t[i] = $time;
      if (!prev_out[i] && evt_rstn_out[i] && mon_en) check_window(i, int'($time - fall_t[i]));
    end
    prev_out = evt_rstn_out;
  end
  task automatic pulse(input int ch, input bit exp_lo);
    @(posedge clk);
    #1 evt[ch] = 1'b1;
    #1 chk("async_assert", 32'(evt_rstn_out[ch]), exp_lo ? 0 : 1);
    #2 evt[ch] = 1'b0;
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    mon_en = 1'b1;
    sys_rstn = 1'b0;
    atpg_tm = 1'b0;
    atpg_rstn = 1'b1;
    evt = '0;
    evt_mask = '0;
    sts_clr = '0;
    repeat (2) @(posedge clk);
    #1 sys_rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1 sys_rstn = 1'b0;
    @(posedge clk);
    #1 sys_rstn = 1'b1;
    @(negedge clk);
    chk("rst_out", 32'(evt_rstn_out), 32'hF);
    chk("rst_any", 32'(any_rstn_out), 1);
    chk("rst_sts", 32'(evt_sts), 0);
    chk("rst_cnt", evt_cnt, 0);
    sb.push_back('{0, 1, 219, 219});
    pulse(0, 1'b1);
    @(negedge clk);
    chk("ch0_low_others_high", 32'(evt_rstn_out), 32'hE);
    chk("any_follows", 32'(any_rstn_out), 0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("ch0_released", 32'(evt_rstn_out), 32'hF);
    chk("any_released", 32'(any_rstn_out), 1);
    chk("sts_ch0", 32'(evt_sts), 32'h1);
    chk("cnt_ch0_only", evt_cnt, 32'h0000_0001);
    for (int i = 0; i < 10; i++) begin
      #($urandom_range(230, 250));
      if ($time % 10 == 0) #1;
      sb.push_back('{2, i + 1, 201, 219});
      evt[2] = 1'b1;
      #1 chk("rand_assert", 32'(evt_rstn_out[2]), 0);
      #2 evt[2] = 1'b0;
    end
    repeat (14) @(posedge clk);
    chk("sts_ch2_set", 32'(evt_sts), 32'h5);
    @(posedge clk);
    #1 sts_clr[2] = 1'b1;
    @(posedge clk);
    #1 sts_clr[2] = 1'b0;
    @(negedge clk);
    chk("sts_ch2_cleared", 32'(evt_sts), 32'h1);
    chk("cnt_ch2_kept", 32'(evt_cnt[23:16]), 10);
    sb.push_back('{1, 2, 359, 359});
    pulse(1, 1'b1);
    repeat (6) @(posedge clk);
    pulse(1, 1'b1);
    repeat (14) @(posedge clk);
    chk("cnt_ch1_retrig", 32'(evt_cnt[15:8]), 2);
    evt_mask = 4'h8;
    for (int i = 0; i < 3; i++) begin
      pulse(3, 1'b0);
      repeat (12) @(posedge clk);
    end
    chk("masked_cnt", 32'(evt_cnt[31:24]), 0);
    chk("masked_sts", 32'(evt_sts[3]), 0);
    chk("masked_out", 32'(evt_rstn_out), 32'hF);
    evt_mask = 4'h0;
    @(posedge clk);
    #1 sys_rstn = 1'b0;
    @(posedge clk);
    #1 sys_rstn = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sb.push_back('{0, i < 255 ? i + 1 : 255, 219, 219});
      pulse(0, 1'b1);
      repeat (11) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    chk("cnt_saturated", 32'(evt_cnt[7:0]), 255);
    @(posedge clk);
    #1 sts_clr[0] = 1'b1;
    @(posedge clk);
    #1 sts_clr[0] = 1'b0;
    @(negedge clk);
    chk("sts_ch0_cleared", 32'(evt_sts[0]), 0);
    sb.push_back('{0, 255, 219, 219});
    pulse(0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 sts_clr[0] = 1'b1;
    @(posedge clk);
    #1 sts_clr[0] = 1'b0;
    @(negedge clk);
    chk("set_wins_over_clr", 32'(evt_sts[0]), 1);
    repeat (12) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    mon_en = 1'b0;
    atpg_tm = 1'b1;
    atpg_rstn = 1'b0;
    #1 chk("atpg_low_out", 32'(evt_rstn_out), 32'h0);
    chk("atpg_low_any", 32'(any_rstn_out), 0);
    @(negedge clk);
    chk("atpg_clears_cnt", evt_cnt, 0);
    chk("atpg_clears_sts", 32'(evt_sts), 0);
    atpg_rstn = 1'b1;
    #1 chk("atpg_high_out", 32'(evt_rstn_out), 32'hF);
    chk("atpg_high_any", 32'(any_rstn_out), 1);
    atpg_tm = 1'b0;
    pulse(1, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("hold_mid", 32'(evt_rstn_out[1]), 0);
    sys_rstn = 1'b0;
    #1 chk("rst_mid_hold_out", 32'(evt_rstn_out), 32'hF);
    chk("rst_mid_hold_cnt", evt_cnt, 0);
    chk("rst_mid_hold_sts", 32'(evt_sts), 0);
    @(posedge clk);
    #1 sys_rstn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("after_rst_out", 32'(evt_rstn_out), 32'hF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
